// File: rtl/video_fx_router_if.sv
// video_fx_router_if: base/effect pixel streams plus routing-config requests and status.
// master drives sources and selects; slave is the router.
interface video_fx_router_if #(
    parameter int NUM_FX = 4,
    parameter int SRC_W  = 3,
    parameter int H_W    = 11,
    parameter int V_W    = 10,
    parameter int PIX_W  = 24
);
    logic                    new_frame;
    logic [NUM_FX*SRC_W-1:0] fx_src;
    logic [SRC_W-1:0]        out_src;
    logic [H_W-1:0]          h_base;
    logic [V_W-1:0]          v_base;
    logic                    ad_base;
    logic [PIX_W-1:0]        pix_base;
    logic [NUM_FX*H_W-1:0]   h_from_fx;
    logic [NUM_FX*V_W-1:0]   v_from_fx;
    logic [NUM_FX-1:0]       ad_from_fx;
    logic [NUM_FX*PIX_W-1:0] pix_from_fx;
    logic [NUM_FX*H_W-1:0]   h_to_fx;
    logic [NUM_FX*V_W-1:0]   v_to_fx;
    logic [NUM_FX-1:0]       ad_to_fx;
    logic [NUM_FX*PIX_W-1:0] pix_to_fx;
    logic [H_W-1:0]          h_out;
    logic [V_W-1:0]          v_out;
    logic                    ad_out;
    logic [PIX_W-1:0]        pix_out;
    logic                    config_pending;
    logic                    config_error;

    modport master (
        output new_frame, fx_src, out_src, h_base, v_base, ad_base, pix_base,
               h_from_fx, v_from_fx, ad_from_fx, pix_from_fx,
        input  h_to_fx, v_to_fx, ad_to_fx, pix_to_fx, h_out, v_out, ad_out, pix_out,
               config_pending, config_error
    );
    modport slave (
        input  new_frame, fx_src, out_src, h_base, v_base, ad_base, pix_base,
               h_from_fx, v_from_fx, ad_from_fx, pix_from_fx,
        output h_to_fx, v_to_fx, ad_to_fx, pix_to_fx, h_out, v_out, ad_out, pix_out,
               config_pending, config_error
    );
endinterface

// File: rtl/video_fx_router.sv
// video_fx_router: routes base and effect-return streams to effect inputs and the output stage;
// new routing is range/loop-checked in the background and committed on a frame boundary.
module video_fx_router #(
    parameter int NUM_FX = 4,
    parameter int SRC_W  = 3,
    parameter int H_W    = 11,
    parameter int V_W    = 10,
    parameter int PIX_W  = 24
) (
    input logic              clk_pixel,
    input logic              rst,
    video_fx_router_if.slave vfx
);
    localparam int CFG_W = (NUM_FX + 1) * SRC_W;
    localparam int CNT_W = $clog2(NUM_FX + 1);
    localparam int NSRC  = 2 ** SRC_W;
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] CHECK = 2'd1;
    localparam logic [1:0] ARMED = 2'd2;

    // Destination j selects at [j*SRC_W +: SRC_W]; j == NUM_FX is the output stream.
    logic [CFG_W-1:0] req, cand_q, cand_d, act_q, act_d;
    logic [1:0] state_q, state_d;
    logic [NUM_FX-1:0] reach_q, reach_d, reach_nx;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic pend_q, pend_d, err_q, err_d;
    logic [NSRC-1:0] reach_ext;
    logic change, in_range, valid;

    logic [NSRC-1:0][H_W-1:0]   h_src;
    logic [NSRC-1:0][V_W-1:0]   v_src;
    logic [NSRC-1:0]            ad_src;
    logic [NSRC-1:0][PIX_W-1:0] pix_src;
    logic [NUM_FX:0][H_W-1:0]   h_q;
    logic [NUM_FX:0][V_W-1:0]   v_q;
    logic [NUM_FX:0]            ad_q;
    logic [NUM_FX:0][PIX_W-1:0] pix_q;

    assign req    = {vfx.out_src, vfx.fx_src};
    assign change = req != cand_q;
    assign valid  = in_range && (&reach_nx);

    // Source 0 (base) is always reachable; out-of-range sources never are.
    always_comb begin
        reach_ext = '0;
        reach_ext[NUM_FX:0] = {reach_q, 1'b1};
        reach_nx = reach_q;
        in_range = 1'b1;
        for (int i = 0; i <= NUM_FX; i++)
            in_range &= cand_q[i*SRC_W +: SRC_W] <= SRC_W'(NUM_FX);
        for (int i = 0; i < NUM_FX; i++)
            reach_nx[i] = reach_q[i] | reach_ext[cand_q[i*SRC_W +: SRC_W]];
    end

    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        act_d   = act_q;
        reach_d = reach_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        err_d   = err_q;
        if (change) begin
            cand_d  = req;
            reach_d = '0;
            cnt_d   = '0;
            state_d = CHECK;
            pend_d  = 1'b0;
        end else if (state_q == CHECK) begin
            reach_d = reach_nx;
            cnt_d   = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(NUM_FX - 1)) begin
                state_d = valid ? ARMED : IDLE;
                pend_d  = valid;
                err_d   = err_q | !valid;
            end
        end else if (state_q == ARMED && vfx.new_frame) begin
            act_d   = cand_q;
            pend_d  = 1'b0;
            err_d   = 1'b0;
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk_pixel) begin
        if (rst) begin
            state_q <= IDLE;
            cand_q  <= '0;
            act_q   <= '0;
            reach_q <= '0;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cand_q  <= cand_d;
            act_q   <= act_d;
            reach_q <= reach_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        h_src   = '0;
        v_src   = '0;
        ad_src  = '0;
        pix_src = '0;
        h_src[NUM_FX:0]   = {vfx.h_from_fx, vfx.h_base};
        v_src[NUM_FX:0]   = {vfx.v_from_fx, vfx.v_base};
        ad_src[NUM_FX:0]  = {vfx.ad_from_fx, vfx.ad_base};
        pix_src[NUM_FX:0] = {vfx.pix_from_fx, vfx.pix_base};
    end

    // Mux on act_d so a commit takes effect on the very edge that samples new_frame.
    always_ff @(posedge clk_pixel) begin
        if (rst) begin
            h_q   <= '0;
            v_q   <= '0;
            ad_q  <= '0;
            pix_q <= '0;
        end else begin
            for (int j = 0; j <= NUM_FX; j++) begin
                h_q[j]   <= h_src[act_d[j*SRC_W +: SRC_W]];
                v_q[j]   <= v_src[act_d[j*SRC_W +: SRC_W]];
                ad_q[j]  <= ad_src[act_d[j*SRC_W +: SRC_W]];
                pix_q[j] <= ad_src[act_d[j*SRC_W +: SRC_W]] ? pix_src[act_d[j*SRC_W +: SRC_W]] : '0;
            end
        end
    end

    assign vfx.h_to_fx        = h_q[NUM_FX-1:0];
    assign vfx.v_to_fx        = v_q[NUM_FX-1:0];
    assign vfx.ad_to_fx       = ad_q[NUM_FX-1:0];
    assign vfx.pix_to_fx      = pix_q[NUM_FX-1:0];
    assign vfx.h_out          = h_q[NUM_FX];
    assign vfx.v_out          = v_q[NUM_FX];
    assign vfx.ad_out         = ad_q[NUM_FX];
    assign vfx.pix_out        = pix_q[NUM_FX];
    assign vfx.config_pending = pend_q;
    assign vfx.config_error   = err_q;
endmodule

// File: tb/tb_video_fx_router.sv
// tb_video_fx_router: table of routing configs plus hand-written commit/restart/reset sequences;
// every cycle's outputs are predicted from the bench's own routing model via a scoreboard.
module tb_video_fx_router;
    localparam int NUM_FX = 4;
    localparam int SRC_W  = 3;
    localparam int H_W    = 11;
    localparam int V_W    = 10;
    localparam int PIX_W  = 24;
    localparam int OUT_W  = (NUM_FX + 1) * (H_W + V_W + 1 + PIX_W);

    typedef struct {
        int src [NUM_FX+1];
        bit ok;
    } vec_t;

    logic clk_pixel = 1'b0;
    logic rst = 1'b1;
    always #5 clk_pixel = ~clk_pixel;

    video_fx_router_if #(.NUM_FX(NUM_FX), .SRC_W(SRC_W), .H_W(H_W), .V_W(V_W), .PIX_W(PIX_W)) vfx ();
    video_fx_router #(.NUM_FX(NUM_FX), .SRC_W(SRC_W), .H_W(H_W), .V_W(V_W), .PIX_W(PIX_W)) dut (
        .clk_pixel(clk_pixel),
        .rst(rst),
        .vfx(vfx)
    );

    int n_checks = 0;
    int n_fail = 0;
    logic [H_W-1:0]   h_s [NUM_FX+1];
    logic [V_W-1:0]   v_s [NUM_FX+1];
    logic             ad_s [NUM_FX+1];
    logic [PIX_W-1:0] pix_s [NUM_FX+1];
    int exp_act [NUM_FX+1];
    int req [NUM_FX+1];
    bit exp_err = 1'b0;
    logic [OUT_W-1:0] sb [$];
    vec_t tbl [8];

    task automatic check(input string name, input logic [OUT_W-1:0] act, input logic [OUT_W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic flags(input bit pend, input bit err);
        check("config_pending", OUT_W'(vfx.config_pending), OUT_W'(pend));
        check("config_error", OUT_W'(vfx.config_error), OUT_W'(err));
    endtask

    task automatic apply_streams();
        vfx.h_base   = h_s[0];
        vfx.v_base   = v_s[0];
        vfx.ad_base  = ad_s[0];
        vfx.pix_base = pix_s[0];
        for (int k = 0; k < NUM_FX; k++) begin
            vfx.h_from_fx[k*H_W +: H_W]       = h_s[k+1];
            vfx.v_from_fx[k*V_W +: V_W]       = v_s[k+1];
            vfx.ad_from_fx[k]                 = ad_s[k+1];
            vfx.pix_from_fx[k*PIX_W +: PIX_W] = pix_s[k+1];
        end
    endtask

    task automatic drive_streams();
        for (int k = 0; k <= NUM_FX; k++) begin
            h_s[k]   = H_W'($urandom);
            v_s[k]   = V_W'($urandom);
            ad_s[k]  = $urandom_range(0, 3) != 0;
            pix_s[k] = PIX_W'($urandom);
        end
        apply_streams();
    endtask

    task automatic apply_cfg();
        for (int k = 0; k < NUM_FX; k++)
            vfx.fx_src[k*SRC_W +: SRC_W] = SRC_W'(req[k]);
        vfx.out_src = SRC_W'(req[NUM_FX]);
    endtask

    function automatic logic [OUT_W-1:0] model();
        logic [NUM_FX*H_W-1:0]   h;
        logic [NUM_FX*V_W-1:0]   v;
        logic [NUM_FX-1:0]       a;
        logic [NUM_FX*PIX_W-1:0] p;
        int s;
        for (int j = 0; j < NUM_FX; j++) begin
            s = exp_act[j];
            h[j*H_W +: H_W]     = h_s[s];
            v[j*V_W +: V_W]     = v_s[s];
            a[j]                = ad_s[s];
            p[j*PIX_W +: PIX_W] = ad_s[s] ? pix_s[s] : PIX_W'(0);
        end
        s = exp_act[NUM_FX];
        return rst ? OUT_W'(0) : {h, v, a, p, h_s[s], v_s[s], ad_s[s], ad_s[s] ? pix_s[s] : PIX_W'(0)};
    endfunction

    task automatic cycle();
        logic [OUT_W-1:0] e;
        sb.push_back(model());
        @(posedge clk_pixel);
        #1;
        e = sb.pop_front();
        check("route", {vfx.h_to_fx, vfx.v_to_fx, vfx.ad_to_fx, vfx.pix_to_fx,
                        vfx.h_out, vfx.v_out, vfx.ad_out, vfx.pix_out}, e);
        drive_streams();
    endtask

    task automatic commit();
        vfx.new_frame = 1'b1;
        exp_act = req;
        exp_err = 1'b0;
        cycle();
        vfx.new_frame = 1'b0;
        flags(1'b0, 1'b0);
        cycle();
    endtask

    task automatic set_vec(input int i, input int a, input int b, input int c, input int d, input int o, input bit ok);
        tbl[i].src = '{a, b, c, d, o};
        tbl[i].ok = ok;
    endtask

    task automatic run_vec(input int i);
        req = tbl[i].src;
        apply_cfg();
        cycle();
        flags(1'b0, exp_err);
        for (int c = 1; c < NUM_FX; c++) begin
            vfx.new_frame = (c == 1);
            cycle();
        end
        vfx.new_frame = 1'b0;
        flags(1'b0, exp_err);
        cycle();
        if (!tbl[i].ok) exp_err = 1'b1;
        flags(tbl[i].ok, exp_err);
        if (tbl[i].ok) begin
            cycle();
            flags(1'b1, exp_err);
            commit();
        end else begin
            for (int f = 0; f < 2; f++) begin
                vfx.new_frame = 1'b1;
                cycle();
                vfx.new_frame = 1'b0;
                cycle();
                cycle();
                flags(1'b0, 1'b1);
            end
        end
    endtask

    task automatic arm(input int a, input int b, input int c, input int d, input int o);
        req = '{a, b, c, d, o};
        apply_cfg();
        for (int k = 0; k <= NUM_FX; k++) cycle();
        flags(1'b1, exp_err);
    endtask

    initial begin
        set_vec(0, 0, 1, 2, 3, 4, 1'b1);
        set_vec(1, 2, 1, 0, 0, 0, 1'b0);
        set_vec(2, 0, 0, 0, 0, 7, 1'b0);
        set_vec(3, 0, 0, 1, 1, 3, 1'b1);
        set_vec(4, 4, 0, 0, 0, 1, 1'b1);
        set_vec(5, 0, 0, 0, 4, 0, 1'b0);
        set_vec(6, 5, 0, 0, 0, 0, 1'b0);
        set_vec(7, 0, 1, 0, 0, 2, 1'b1);
        exp_act = '{0, 0, 0, 0, 0};
        req = '{0, 0, 0, 0, 0};
        apply_cfg();
        vfx.new_frame = 1'b0;
        drive_streams();

        rst = 1'b1;
        cycle();
        cycle();
        flags(1'b0, 1'b0);
        rst = 1'b0;
        vfx.new_frame = 1'b1;
        cycle();
        vfx.new_frame = 1'b0;
        cycle();
        flags(1'b0, 1'b0);

        pix_s[0] = 24'hABCDEF;
        ad_s[0] = 1'b1;
        apply_streams();
        cycle();
        check("pix_out_base", OUT_W'(vfx.pix_out), OUT_W'(24'hABCDEF));
        check("pix_to_fx_base", OUT_W'(vfx.pix_to_fx), OUT_W'({NUM_FX{24'hABCDEF}}));
        pix_s[0] = 24'hABCDEF;
        ad_s[0] = 1'b0;
        apply_streams();
        cycle();
        check("pix_out_blank", OUT_W'(vfx.pix_out), OUT_W'(0));

        for (int i = 0; i < 8; i++) run_vec(i);

        // Change coinciding with new_frame while armed: no commit, check restarts.
        arm(0, 0, 0, 0, 1);
        req = '{0, 0, 0, 0, 2};
        apply_cfg();
        vfx.new_frame = 1'b1;
        cycle();
        vfx.new_frame = 1'b0;
        flags(1'b0, 1'b0);
        for (int c = 1; c < NUM_FX; c++) cycle();
        flags(1'b0, 1'b0);
        cycle();
        flags(1'b1, 1'b0);
        commit();

        // Change on the evaluation edge of a loop config: restart wins, no error.
        req = '{2, 1, 0, 0, 0};
        apply_cfg();
        cycle();
        for (int c = 1; c < NUM_FX; c++) cycle();
        req = '{0, 0, 0, 0, 3};
        apply_cfg();
        cycle();
        flags(1'b0, 1'b0);
        for (int c = 1; c < NUM_FX; c++) cycle();
        flags(1'b0, 1'b0);
        cycle();
        flags(1'b1, 1'b0);
        commit();

        // Reset while armed drops the candidate and returns routing to base.
        arm(0, 0, 0, 0, 4);
        rst = 1'b1;
        cycle();
        cycle();
        flags(1'b0, 1'b0);
        exp_act = '{0, 0, 0, 0, 0};
        rst = 1'b0;
        for (int c = 0; c < NUM_FX; c++) cycle();
        flags(1'b0, 1'b0);
        cycle();
        flags(1'b1, 1'b0);
        cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
